// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - sequences a source-select mux over enabled sources and streams captured samples
module mux_scan_sequencer #(
    parameter int NUM_SRC = 6,
    parameter int DATA_W  = 4,
    parameter int SEL_W   = 3,
    parameter int SETTLE  = 1
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               start,
    input  logic [NUM_SRC-1:0] enable_mask,
    output logic [SEL_W-1:0]   sel,
    input  logic [DATA_W-1:0]  mux_out,
    output logic [DATA_W-1:0]  out_data,
    output logic [SEL_W-1:0]   out_idx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_EMIT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_SRC-1:0] mask_q;
    logic [CNT_W-1:0]   cnt;
    logic               first_found;
    logic [SEL_W-1:0]   first_idx;
    logic               next_found;
    logic [SEL_W-1:0]   next_idx;
    logic               settle_last;
    logic               handshake;

    // Priority search: lowest enabled source overall (for start) and lowest latched source above sel.
    // Walking downward lets the last hit win, so the lowest matching index is kept.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (enable_mask[i]) begin
                first_found = 1'b1;
                first_idx   = SEL_W'(i);
            end
            if (mask_q[i] && (SEL_W'(i) > sel)) begin
                next_found = 1'b1;
                next_idx   = SEL_W'(i);
            end
        end
    end

    assign settle_last = (cnt == CNT_W'(SETTLE - 1));
    assign handshake   = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && first_found) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_last) begin
                    state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (handshake) begin
                    state_nxt = next_found ? S_SETTLE : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: select, settle counter, captured beat, busy/done flags.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sel       <= '0;
            mask_q    <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_q <= enable_mask;
                        if (first_found) begin
                            sel  <= first_idx;
                            busy <= 1'b1;
                            cnt  <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_last) begin
                        out_data  <= mux_out;
                        out_idx   <= sel;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (next_found) begin
                            sel <= next_idx;
                        end else begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - scoreboard bench for mux_scan_sequencer
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       areset;
    logic       start;
    logic [5:0] enable_mask;
    logic [2:0] sel;
    logic [3:0] mux_out;
    logic [3:0] out_data;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    logic [3:0] src_data [6];
    logic [7:0] sb_q [$];
    int         hs_cyc [$];
    logic [5:0] cur_mask = 6'h0;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         done_cyc = 0;
    int         done_cnt = 0;
    logic       prev_done = 1'b0;

    mux_scan_sequencer dut (
        .clk         (clk),
        .areset      (areset),
        .start       (start),
        .enable_mask (enable_mask),
        .sel         (sel),
        .mux_out     (mux_out),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always_comb begin
        mux_out = 4'h0;
        if (int'(sel) < 6) mux_out = src_data[int'(sel)];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted beat, polices sel and done.
    always @(negedge clk) begin
        logic [7:0] e;
        logic       en;
        if (!areset) begin
            if (busy) begin
                en = (int'(sel) < 6) ? cur_mask[sel] : 1'b0;
                check("sel_enabled", en, 1);
            end
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("beat_idx", out_idx, e[6:4]);
                    check("beat_data", out_data, e[3:0]);
                end
            end
            if (done) begin
                check("done_single", prev_done, 0);
                done_cnt++;
                done_cyc = cyc;
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic start_scan(input logic [5:0] m);
        hs_cyc.delete();
        done_cnt = 0;
        cur_mask = m;
        for (int i = 0; i < 6; i++) begin
            if (m[i]) sb_q.push_back({1'b0, 3'(i), src_data[i]});
        end
        enable_mask = m;
        start = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (done_cnt == 0 && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_timeout", done_cnt != 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        areset = 1'b1;
        start = 1'b0;
        enable_mask = 6'h0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) src_data[i] = 4'(i + 1);

        repeat (2) @(posedge clk);
        #1;
        check("rst_sel", sel, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        areset = 1'b0;
        @(posedge clk);
        #1;

        // T1: all sources, full throughput
        start_scan(6'b111111);
        wait_done(100);
        check("t1_beats", hs_cyc.size(), 6);
        if (hs_cyc.size() == 6) begin
            check("t1_first_lat", hs_cyc[0] - start_cyc, 1);
            for (int i = 1; i < 6; i++) check("t1_interval", hs_cyc[i] - hs_cyc[i-1], 2);
            check("t1_done_lat", done_cyc - hs_cyc[5], 1);
        end
        check("t1_total", done_cyc - start_cyc, 12);
        check("t1_sb_empty", sb_q.size(), 0);
        check("t1_sel_last", sel, 5);

        // T2: sparse mask, disabled sources skipped
        start_scan(6'b100101);
        wait_done(100);
        check("t2_beats", hs_cyc.size(), 3);
        check("t2_total", done_cyc - start_cyc, 6);
        check("t2_sb_empty", sb_q.size(), 0);

        // T3: backpressure while the mux input changes
        src_data[2] = 4'h3;
        out_ready = 1'b0;
        start_scan(6'b000100);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t3_valid_timeout", out_valid, 1);
        src_data[2] = 4'hC;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_data", out_data, 4'h3);
            check("t3_hold_sel", sel, 2);
        end
        out_ready = 1'b1;
        wait_done(20);
        check("t3_beats", hs_cyc.size(), 1);
        check("t3_sb_empty", sb_q.size(), 0);
        src_data[2] = 4'h3;

        // T4: empty mask
        start_scan(6'b000000);
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        check("t4_valid", out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_done_cnt", done_cnt, 1);
        check("t4_done_cyc", done_cyc, start_cyc);
        check("t4_beats", hs_cyc.size(), 0);

        // T5: start while busy is ignored
        start_scan(6'b111111);
        repeat (3) @(posedge clk);
        #1;
        enable_mask = 6'b000001;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(100);
        check("t5_beats", hs_cyc.size(), 6);
        check("t5_sb_empty", sb_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_restart", busy, 0);
        check("t5_done_cnt", done_cnt, 1);

        // T6: asynchronous reset during EMIT of idx 3
        start_scan(6'b111111);
        n = 0;
        while (sel != 3'd3 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_reach_idx3", sel, 3);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_emit_valid", out_valid, 1);
        check("t6_emit_idx", out_idx, 3);
        #2 areset = 1'b1;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_sel", sel, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_done", done, 0);
        sb_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #3 areset = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("t6_idle_busy", busy, 0);
            check("t6_idle_valid", out_valid, 0);
        end
        check("t6_no_done", done_cnt, 0);
        check("final_sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
